mem_access: RTL



---
 rtl/mem_access.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// MEM pipeline stage: issues loads/stores on the data-SRAM request/ack bus, aligns and extends load data.
// Latency: non-memory ops pass through in zero cycles; memory ops stall >= 1 cycle, then present in DONE.
// Backpressure: STALL_REQ while a transaction is outstanding; DONE holds its result while HOLD is high.
//
// Ports:
//   CLK, RST                         clock, asynchronous active-high reset
//   EX_GPR_WE/WDATA/WADDR            writeback intent from ex_mem (WDATA is the ALU result)
//   EX_MEM_OP/ADDR/SDATA             memory op code, effective address, store data
//   HOLD                             mem_wb not accepting this cycle
//   DATA_REQ/WR/BE/ADDR/WDATA        request side of the data bus
//   DATA_ADDR_OK/OK/RDATA            request accept, response valid, read word
//   STALL_REQ                        freeze IF..EX/MEM while a transaction is in flight
//   MEM_GPR_WE/WDATA/WADDR           writeback to mem_wb
// Optional: define MEM_ALIGN_CHECK_EN to add MEM_ADEL/MEM_ADES and suppress misaligned accesses.
module mem_access #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EX_GPR_WE,
    input  logic [DATA_W-1:0] EX_GPR_WDATA,
    input  logic [4:0]        EX_GPR_WADDR,
    input  logic [3:0]        EX_MEM_OP,
    input  logic [ADDR_W-1:0] EX_MEM_ADDR,
    input  logic [DATA_W-1:0] EX_MEM_SDATA,
    input  logic              HOLD,
    output logic              DATA_REQ,
    output logic              DATA_WR,
    output logic [3:0]        DATA_BE,
    output logic [ADDR_W-1:0] DATA_ADDR,
    output logic [DATA_W-1:0] DATA_WDATA,
    input  logic              DATA_ADDR_OK,
    input  logic              DATA_OK,
    input  logic [DATA_W-1:0] DATA_RDATA,
    output logic              STALL_REQ,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              MEM_ADEL,
    output logic              MEM_ADES,
`endif
    output logic              MEM_GPR_WE,
    output logic [DATA_W-1:0] MEM_GPR_WDATA,
    output logic [4:0]        MEM_GPR_WADDR
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] rbuf;

    logic              is_load;
    logic              is_store;
    logic              is_mem;
    logic              misalign;
    logic              issue;
    logic              capture;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_ext;
    logic [3:0]        st_be;
    logic [DATA_W-1:0] st_wdata;

    assign is_load  = (EX_MEM_OP >= OP_LB) && (EX_MEM_OP <= OP_LW);
    assign is_store = (EX_MEM_OP >= OP_SB) && (EX_MEM_OP <= OP_SW);
    assign is_mem   = is_load | is_store;

`ifdef MEM_ALIGN_CHECK_EN
    logic adel_c;
    logic ades_c;
    assign adel_c   = (((EX_MEM_OP == OP_LH) || (EX_MEM_OP == OP_LHU)) && EX_MEM_ADDR[0])
                    || ((EX_MEM_OP == OP_LW) && (EX_MEM_ADDR[1:0] != 2'b00));
    assign ades_c   = ((EX_MEM_OP == OP_SH) && EX_MEM_ADDR[0])
                    || ((EX_MEM_OP == OP_SW) && (EX_MEM_ADDR[1:0] != 2'b00));
    assign misalign = adel_c | ades_c;
`else
    assign misalign = 1'b0;
`endif

    // REQ keeps the request up regardless of op decode: the pipeline is frozen by our stall,
    // so the EX/MEM inputs are the same ones that started the transaction.
    assign issue   = ((state == S_IDLE) && is_mem && !misalign) || (state == S_REQ);
    // DATA_OK only counts in WAIT, or together with the accept in the issue cycle.
    assign capture = (issue && DATA_ADDR_OK && DATA_OK) || ((state == S_WAIT) && DATA_OK);

    // Load alignment and extension
    always_comb begin
        case (EX_MEM_ADDR[1:0])
            2'd0:    ld_byte = DATA_RDATA[7:0];
            2'd1:    ld_byte = DATA_RDATA[15:8];
            2'd2:    ld_byte = DATA_RDATA[23:16];
            default: ld_byte = DATA_RDATA[31:24];
        endcase
        ld_half = EX_MEM_ADDR[1] ? DATA_RDATA[31:16] : DATA_RDATA[15:0];
        case (EX_MEM_OP)
            OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_ext = {24'h0, ld_byte};
            OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_ext = {16'h0, ld_half};
            OP_LW:   ld_ext = DATA_RDATA;
            default: ld_ext = '0;
        endcase
    end

    // Store lane replication and byte enables; loads read the whole word
    always_comb begin
        case (EX_MEM_OP)
            OP_SB: begin
                st_be    = 4'b0001 << EX_MEM_ADDR[1:0];
                st_wdata = {4{EX_MEM_SDATA[7:0]}};
            end
            OP_SH: begin
                st_be    = EX_MEM_ADDR[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{EX_MEM_SDATA[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = EX_MEM_SDATA;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            rbuf  <= '0;
        end else begin
            if (capture) begin
                rbuf <= ld_ext;
            end
            case (state)
                S_IDLE, S_REQ: begin
                    if (issue) begin
                        if (DATA_ADDR_OK) begin
                            state <= DATA_OK ? S_DONE : S_WAIT;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_WAIT: begin
                    if (DATA_OK) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!HOLD) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        DATA_REQ      = 1'b0;
        DATA_WR       = 1'b0;
        DATA_BE       = 4'b0000;
        DATA_ADDR     = '0;
        DATA_WDATA    = '0;
        STALL_REQ     = 1'b0;
        MEM_GPR_WE    = 1'b0;
        MEM_GPR_WDATA = '0;
        MEM_GPR_WADDR = 5'd0;
`ifdef MEM_ALIGN_CHECK_EN
        MEM_ADEL      = 1'b0;
        MEM_ADES      = 1'b0;
`endif
        if (!RST) begin
            case (state)
                S_IDLE: begin
                    if (!is_mem) begin
                        MEM_GPR_WE    = EX_GPR_WE;
                        MEM_GPR_WDATA = EX_GPR_WDATA;
                        MEM_GPR_WADDR = EX_GPR_WADDR;
                    end else if (!misalign) begin
                        STALL_REQ = 1'b1;
                    end
                end
                S_REQ:  STALL_REQ = 1'b1;
                S_WAIT: STALL_REQ = 1'b1;
                S_DONE: begin
                    MEM_GPR_WE    = is_load & EX_GPR_WE;
                    MEM_GPR_WDATA = rbuf;
                    MEM_GPR_WADDR = EX_GPR_WADDR;
                end
                default: ;
            endcase
            if (issue) begin
                DATA_REQ   = 1'b1;
                DATA_WR    = is_store;
                DATA_BE    = st_be;
                DATA_ADDR  = {EX_MEM_ADDR[ADDR_W-1:2], 2'b00};
                DATA_WDATA = st_wdata;
            end
`ifdef MEM_ALIGN_CHECK_EN
            MEM_ADEL = (state == S_IDLE) && adel_c;
            MEM_ADES = (state == S_IDLE) && ades_c;
`endif
        end
    end

endmodule
